// File: rtl/crc8_frame_pkg.sv
// Shared types and constants for the crc8 byte-stream feeder.
// The crc8 engine lives in the parent; these constants describe the engine being driven.
package crc8_frame_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StEmit,
    StCrc
  } state_e;

  localparam logic [7:0] CRC8_INIT = 8'hFF;
  localparam logic [7:0] CRC8_POLY = 8'h69;

endpackage

// File: rtl/crc8_frame_tx.sv
// Serialises framed bytes MSB-first into an external bit-serial crc8 engine, forwards each byte,
// and appends the crc8 result after the last byte of a frame. Define CRC8_STATS_EN for frame_cnt.
module crc8_frame_tx
  import crc8_frame_pkg::*;
`ifdef CRC8_STATS_EN
#(
  parameter int unsigned FRAME_CNT_W = 16
)
`endif
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [7:0]             m_data,
  output logic                   m_last,
  output logic                   crc_rst,
  output logic                   crc_bit,
  output logic                   crc_shift,
  input  logic [7:0]             crc_result
`ifdef CRC8_STATS_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  state_e      state_q;
  logic [7:0]  sreg_q;
  logic [2:0]  cnt_q;
  logic        last_q;
  logic        shift_q;
  logic        m_valid_q;
  logic        m_last_q;
  logic [7:0]  m_data_q;
  logic        crc_done;

  assign s_ready   = (state_q == StIdle) & ~rst;
  assign crc_done  = (state_q == StCrc) & m_ready;
  // The engine reloads its init value on reset and on the CRC byte handshake.
  assign crc_rst   = rst | crc_done;
  assign crc_shift = shift_q;
  assign crc_bit   = sreg_q[7];
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign m_data    = m_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sreg_q    <= 8'h00;
      cnt_q     <= 3'd7;
      last_q    <= 1'b0;
      shift_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_valid) begin
            sreg_q   <= s_data;
            m_data_q <= s_data;
            last_q   <= s_last;
            shift_q  <= 1'b1;
            cnt_q    <= 3'd7;
            state_q  <= StShift;
          end
        end
        StShift: begin
          sreg_q <= {sreg_q[6:0], 1'b0};
          cnt_q  <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            shift_q   <= 1'b0;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            state_q   <= StEmit;
          end
        end
        StEmit: begin
          if (m_ready) begin
            if (last_q) begin
              // Final shift landed one cycle before EMIT, so crc_result is settled here.
              m_data_q <= crc_result;
              m_last_q <= 1'b1;
              state_q  <= StCrc;
            end else begin
              m_valid_q <= 1'b0;
              state_q   <= StIdle;
            end
          end
        end
        StCrc: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CRC8_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (crc_done) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_crc8_frame_tx.sv
// Directed bench for crc8_frame_tx with a behavioural crc8 engine beside it.
// Expected CRC bytes are hand-computed from init 8'hFF, poly 8'h69, MSB-first.
module tb_crc8_frame_tx;

`ifdef CRC8_STATS_EN
  localparam int unsigned FW = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic       crc_rst;
  logic       crc_bit;
  logic       crc_shift;
  logic [7:0] crc_result;
`ifdef CRC8_STATS_EN
  logic [FW-1:0] frame_cnt;
`endif

  int n_pass   = 0;
  int n_total  = 0;
  int n_frames = 0;

  always #5 clk = ~clk;

`ifdef CRC8_STATS_EN
  crc8_frame_tx #(
    .FRAME_CNT_W(FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .crc_rst    (crc_rst),
    .crc_bit    (crc_bit),
    .crc_shift  (crc_shift),
    .crc_result (crc_result),
    .frame_cnt  (frame_cnt)
  );
`else
  crc8_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .crc_rst    (crc_rst),
    .crc_bit    (crc_bit),
    .crc_shift  (crc_shift),
    .crc_result (crc_result)
  );
`endif

  // Behavioural crc8 engine, wired as the parent would.
  logic [7:0] crc_q;
  always_ff @(posedge clk) begin
    if (crc_rst) crc_q <= 8'hFF;
    else if (crc_shift) crc_q <= {crc_q[6:0], 1'b0} ^ (crc_q[7] ? 8'h69 : 8'h00) ^ {7'b0, crc_bit};
  end
  assign crc_result = crc_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic frame_done();
    n_frames++;
`ifdef CRC8_STATS_EN
    check("frame_cnt", {30'b0, frame_cnt}, n_frames % 4);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int w = 0;
    while (s_ready !== 1'b1 && w < 30) begin
      tick();
      w++;
    end
    if (w >= 30) check("s_ready_timeout", {31'b0, s_ready}, 1);
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Expects m_ready already high; returns cycles from accept to m_valid.
  task automatic expect_byte(input logic [7:0] b, input logic last, input logic [7:0] crc,
                             input string tag, output int lat);
    lat = 0;
    while (m_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_valid"}, {31'b0, m_valid}, 1);
    check({tag, "_data"}, {24'b0, m_data}, {24'b0, b});
    check({tag, "_last0"}, {31'b0, m_last}, 0);
    tick();
    if (last) begin
      check({tag, "_crc_valid"}, {31'b0, m_valid}, 1);
      check({tag, "_crc_data"}, {24'b0, m_data}, {24'b0, crc});
      check({tag, "_crc_last"}, {31'b0, m_last}, 1);
      check({tag, "_crc_rst"}, {31'b0, crc_rst}, 1);
      tick();
      frame_done();
    end
    check({tag, "_idle"}, {31'b0, m_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] bits;
    int shifts;

    tick();
    tick();
    check("rst_s_ready", {31'b0, s_ready}, 0);
    check("rst_m_valid", {31'b0, m_valid}, 0);
    check("rst_m_last", {31'b0, m_last}, 0);
    check("rst_m_data", {24'b0, m_data}, 0);
    check("rst_crc_shift", {31'b0, crc_shift}, 0);
    check("rst_crc_bit", {31'b0, crc_bit}, 0);
    check("rst_crc_rst", {31'b0, crc_rst}, 1);
`ifdef CRC8_STATS_EN
    check("rst_frame_cnt", {30'b0, frame_cnt}, 0);
`endif
    rst = 1'b0;
    #1;
    check("idle_s_ready", {31'b0, s_ready}, 1);
    check("idle_crc_rst", {31'b0, crc_rst}, 0);

    // Single-byte frame {00}: CRC 8'h26, byte valid 8 cycles after accept edge.
    send_byte(8'h00, 1'b1);
    expect_byte(8'h00, 1'b1, 8'h26, "f00", lat);
    check("f00_latency", lat, 8);

    // 8'hA5 serialised MSB-first.
    send_byte(8'hA5, 1'b1);
    bits = 8'h00;
    shifts = 0;
    for (int i = 0; i < 8; i++) begin
      if (crc_shift === 1'b1) shifts++;
      bits = {bits[6:0], crc_bit};
      tick();
    end
    check("a5_bits", {24'b0, bits}, 32'hA5);
    check("a5_shift_cnt", shifts, 8);
    check("a5_shift_off", {31'b0, crc_shift}, 0);
    expect_byte(8'hA5, 1'b1, 8'h83, "fa5", lat);

    // Back-to-back {00}{00}: each restarts from init.
    send_byte(8'h00, 1'b1);
    expect_byte(8'h00, 1'b1, 8'h26, "b2b_a", lat);
    send_byte(8'h00, 1'b1);
    expect_byte(8'h00, 1'b1, 8'h26, "b2b_b", lat);

    // Two-byte frame {00,00}: state carries across bytes, no CRC after first byte.
    send_byte(8'h00, 1'b0);
    expect_byte(8'h00, 1'b0, 8'h00, "two_a", lat);
    send_byte(8'h00, 1'b1);
    expect_byte(8'h00, 1'b1, 8'h68, "two_b", lat);

    // Backpressure in EMIT and CRC.
    m_ready = 1'b0;
    send_byte(8'h00, 1'b1);
    lat = 0;
    while (m_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_emit_valid", {31'b0, m_valid}, 1);
      check("bp_emit_data", {24'b0, m_data}, 0);
      check("bp_emit_last", {31'b0, m_last}, 0);
      check("bp_emit_shift", {31'b0, crc_shift}, 0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_crc_valid", {31'b0, m_valid}, 1);
      check("bp_crc_data", {24'b0, m_data}, 32'h26);
      check("bp_crc_last", {31'b0, m_last}, 1);
      check("bp_crc_rst", {31'b0, crc_rst}, 0);
      tick();
    end
    m_ready = 1'b1;
    #1;
    check("bp_crc_done", {31'b0, crc_rst}, 1);
    tick();
    check("bp_idle", {31'b0, m_valid}, 0);
    frame_done();

    // Reset in SHIFT of a 3-byte frame discards it.
    send_byte(8'h11, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_crc_rst", {31'b0, crc_rst}, 1);
    tick();
    rst = 1'b0;
    #1;
    check("mid_m_valid", {31'b0, m_valid}, 0);
    check("mid_s_ready", {31'b0, s_ready}, 1);
    check("mid_shift", {31'b0, crc_shift}, 0);
    n_frames = 0;
`ifdef CRC8_STATS_EN
    check("mid_frame_cnt", {30'b0, frame_cnt}, 0);
`endif
    send_byte(8'h00, 1'b1);
    expect_byte(8'h00, 1'b1, 8'h26, "post_rst", lat);

    // Further frames; with stats the 2-bit counter runs 2, 3, then wraps to 0.
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h00, 1'b1);
      expect_byte(8'h00, 1'b1, 8'h26, "wrap", lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
